lsu_completion_tracker: RTL and testbench

- Load/store unit front end; the producer side of the scoreboard clear interface.
- Accepts memory instructions from the scheduler and queues them in order.
- Issues each instruction to the data memory port and matches in-order memory responses to queued entries.
- Per completion: pulses done_bit with warp/mask toward the scoreboard; for loads, also presents write-back data to the register file.

---
 rtl/gu_pkg.sv | 27 ++
 rtl/lsu_tracker_mem.sv | 40 ++++
 rtl/lsu_completion_tracker.sv | 180 ++++++++++++++++++
 tb/tb_lsu_completion_tracker.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gu_pkg.sv
// ---------------------------------------------------------------------------
// gu_pkg
// Types and constants shared by the GPU load/store unit blocks.
//   NUM_WARPS / WARP_NUM_W   : warp count and the width of a warp number
//   THREAD_MASK_W            : width of the encoded thread mask
//   LSU_ADDR_W / LSU_DATA_W  : address and data widths held in a tracker
//                              entry (the tracker top must be built with
//                              matching ADDR_WIDTH / DATA_WIDTH)
//   lsu_entry_t              : one queued memory instruction
// ---------------------------------------------------------------------------
package gu_pkg;

    localparam int NUM_WARPS     = 4;
    localparam int WARP_NUM_W    = $clog2(NUM_WARPS);
    localparam int THREAD_MASK_W = 4;
    localparam int LSU_ADDR_W    = 16;
    localparam int LSU_DATA_W    = 16;

    typedef struct packed {
        logic [WARP_NUM_W-1:0]    warp;
        logic [THREAD_MASK_W-1:0] mask;
        logic                     is_store;
        logic [LSU_ADDR_W-1:0]    addr;
        logic [LSU_DATA_W-1:0]    wdata;
    } lsu_entry_t;

endpackage

// File: rtl/lsu_tracker_mem.sv
// ---------------------------------------------------------------------------
// lsu_tracker_mem
// DEPTH-entry register array holding queued LSU instructions.
// One synchronous write port, two asynchronous read ports (one for the
// request side, one for the completion side).
// Ports:
//   clk                    clock
//   wr_en/wr_idx/wr_entry  write port
//   rd_a_idx/rd_a_entry    read port A (send pointer)
//   rd_b_idx/rd_b_entry    read port B (completion pointer)
// ---------------------------------------------------------------------------
module lsu_tracker_mem
    import gu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  lsu_entry_t       wr_entry,
    input  logic [IDX_W-1:0] rd_a_idx,
    output lsu_entry_t       rd_a_entry,
    input  logic [IDX_W-1:0] rd_b_idx,
    output lsu_entry_t       rd_b_entry
);

    lsu_entry_t entry_reg [DEPTH];

    // Contents need no reset: the pointers decide which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_reg[wr_idx] <= wr_entry;
        end
    end

    assign rd_a_entry = entry_reg[rd_a_idx];
    assign rd_b_entry = entry_reg[rd_b_idx];

endmodule

// File: rtl/lsu_completion_tracker.sv
// ---------------------------------------------------------------------------
// lsu_completion_tracker
// Load/store unit front end. Queues scheduler memory instructions in order,
// issues them to the data memory port, matches in-order memory responses to
// queued entries and pulses done_bit (plus load write-back) one cycle after
// each response.
// Ports:
//   clk, reset (synchronous, active high)
//   issue_*       scheduler side valid/ready instruction input
//   mem_req_*     memory request valid/ready output
//   mem_resp_*    in-order memory responses (load data and store acks)
//   done_bit, warp_num_clear, threads_mask_clear   scoreboard clear
//   wb_*          register file write-back for loads
//   perf_completions, perf_full_stalls   only when LSU_TRACKER_PERF_EN is
//                 defined
// Optional build macro: LSU_TRACKER_PERF_EN (performance counters).
// ---------------------------------------------------------------------------
module lsu_completion_tracker
    import gu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [WARP_NUM_W-1:0]    issue_warp_num,
    input  logic [THREAD_MASK_W-1:0] issue_threads_mask,
    input  logic                     issue_is_store,
    input  logic [ADDR_WIDTH-1:0]    issue_addr,
    input  logic [DATA_WIDTH-1:0]    issue_wdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_resp_rdata,
    output logic                     done_bit,
    output logic [WARP_NUM_W-1:0]    warp_num_clear,
    output logic [THREAD_MASK_W-1:0] threads_mask_clear,
    output logic                     wb_valid,
    output logic [WARP_NUM_W-1:0]    wb_warp_num,
    output logic [THREAD_MASK_W-1:0] wb_threads_mask,
    output logic [DATA_WIDTH-1:0]    wb_data
`ifdef LSU_TRACKER_PERF_EN
    ,
    output logic [31:0]              perf_completions,
    output logic [31:0]              perf_full_stalls
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W-1:0] send_ptr_reg;
    logic [PTR_W-1:0] comp_ptr_reg;
    logic [PTR_W-1:0] count;

    logic                     done_reg;
    logic [WARP_NUM_W-1:0]    clear_warp_reg;
    logic [THREAD_MASK_W-1:0] clear_mask_reg;
    logic                     wb_valid_reg;
    logic [DATA_WIDTH-1:0]    wb_data_reg;

    logic       accept;
    logic       send;
    logic       retire;
    lsu_entry_t wr_entry;
    lsu_entry_t send_entry;
    lsu_entry_t comp_entry;
    logic       entry_unused;

    // Full is judged on registered state only; a retire in the same cycle
    // frees the slot for the following cycle.
    assign count       = tail_reg - comp_ptr_reg;
    assign issue_ready = (count != PTR_W'(DEPTH));

    assign accept        = issue_valid && issue_ready;
    assign mem_req_valid = (send_ptr_reg != tail_reg);
    assign send          = mem_req_valid && mem_req_ready;
    assign retire        = mem_resp_valid && (comp_ptr_reg != send_ptr_reg);

    always_comb begin
        wr_entry          = '0;
        wr_entry.warp     = issue_warp_num;
        wr_entry.mask     = issue_threads_mask;
        wr_entry.is_store = issue_is_store;
        wr_entry.addr     = LSU_ADDR_W'(issue_addr);
        wr_entry.wdata    = LSU_DATA_W'(issue_wdata);
    end

    lsu_tracker_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk        (clk),
        .wr_en      (accept),
        .wr_idx     (tail_reg[IDX_W-1:0]),
        .wr_entry   (wr_entry),
        .rd_a_idx   (send_ptr_reg[IDX_W-1:0]),
        .rd_a_entry (send_entry),
        .rd_b_idx   (comp_ptr_reg[IDX_W-1:0]),
        .rd_b_entry (comp_entry)
    );

    // Request fields are forced to zero when idle so stale slot contents
    // never appear on the port (including right after reset).
    assign mem_req_we    = mem_req_valid && send_entry.is_store;
    assign mem_req_addr  = mem_req_valid ? ADDR_WIDTH'(send_entry.addr) : '0;
    assign mem_req_wdata = mem_req_valid ? DATA_WIDTH'(send_entry.wdata) : '0;

    // Fields each read port does not need.
    assign entry_unused = ^{send_entry.warp, send_entry.mask,
                            comp_entry.addr, comp_entry.wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            tail_reg       <= '0;
            send_ptr_reg   <= '0;
            comp_ptr_reg   <= '0;
            done_reg       <= 1'b0;
            clear_warp_reg <= '0;
            clear_mask_reg <= '0;
            wb_valid_reg   <= 1'b0;
            wb_data_reg    <= '0;
        end else begin
            if (accept) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (send) begin
                send_ptr_reg <= send_ptr_reg + PTR_W'(1);
            end
            if (retire) begin
                comp_ptr_reg <= comp_ptr_reg + PTR_W'(1);
            end
            done_reg       <= retire;
            clear_warp_reg <= retire ? comp_entry.warp : '0;
            clear_mask_reg <= retire ? comp_entry.mask : '0;
            wb_valid_reg   <= retire && !comp_entry.is_store;
            wb_data_reg    <= (retire && !comp_entry.is_store) ? mem_resp_rdata : '0;
        end
    end

    assign done_bit           = done_reg;
    assign warp_num_clear     = clear_warp_reg;
    assign threads_mask_clear = clear_mask_reg;
    // Write-back identity equals the clear identity, gated to loads.
    assign wb_valid           = wb_valid_reg;
    assign wb_warp_num        = wb_valid_reg ? clear_warp_reg : '0;
    assign wb_threads_mask    = wb_valid_reg ? clear_mask_reg : '0;
    assign wb_data            = wb_data_reg;

`ifdef LSU_TRACKER_PERF_EN
    logic [31:0] perf_completions_reg;
    logic [31:0] perf_full_stalls_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_completions_reg <= '0;
            perf_full_stalls_reg <= '0;
        end else begin
            if (done_reg) begin
                perf_completions_reg <= perf_completions_reg + 32'd1;
            end
            if (issue_valid && !issue_ready) begin
                perf_full_stalls_reg <= perf_full_stalls_reg + 32'd1;
            end
        end
    end

    assign perf_completions = perf_completions_reg;
    assign perf_full_stalls = perf_full_stalls_reg;
`endif

endmodule

// File: tb/tb_lsu_completion_tracker.sv
module tb_lsu_completion_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_warp_num;
    logic [3:0]  issue_threads_mask;
    logic        issue_is_store;
    logic [15:0] issue_addr;
    logic [15:0] issue_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [15:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [15:0] mem_resp_rdata;
    logic        done_bit;
    logic [1:0]  warp_num_clear;
    logic [3:0]  threads_mask_clear;
    logic        wb_valid;
    logic [1:0]  wb_warp_num;
    logic [3:0]  wb_threads_mask;
    logic [15:0] wb_data;
`ifdef LSU_TRACKER_PERF_EN
    logic [31:0] perf_completions;
    logic [31:0] perf_full_stalls;
`endif

    lsu_completion_tracker #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .DEPTH      (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_warp_num     (issue_warp_num),
        .issue_threads_mask (issue_threads_mask),
        .issue_is_store     (issue_is_store),
        .issue_addr         (issue_addr),
        .issue_wdata        (issue_wdata),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_wdata      (mem_req_wdata),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_rdata     (mem_resp_rdata),
        .done_bit           (done_bit),
        .warp_num_clear     (warp_num_clear),
        .threads_mask_clear (threads_mask_clear),
        .wb_valid           (wb_valid),
        .wb_warp_num        (wb_warp_num),
        .wb_threads_mask    (wb_threads_mask),
        .wb_data            (wb_data)
`ifdef LSU_TRACKER_PERF_EN
        ,
        .perf_completions   (perf_completions),
        .perf_full_stalls   (perf_full_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic [1:0]  warp;
        logic [3:0]  mask;
        logic        wb;
        logic [15:0] data;
    } comp_t;

    req_t  req_q[$];
    comp_t comp_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input int w, input int m, input int st, input int a, input int d);
        issue_valid        = 1'b1;
        issue_warp_num     = 2'(w);
        issue_threads_mask = 4'(m);
        issue_is_store     = 1'(st);
        issue_addr         = 16'(a);
        issue_wdata        = 16'(d);
    endtask

    // Expected request and expected completion for one instruction.
    task automatic push_exp(input int w, input int m, input int st, input int a, input int d, input int r);
        req_t  rq;
        comp_t cp;
        rq.we    = 1'(st);
        rq.addr  = 16'(a);
        rq.wdata = 16'(d);
        cp.warp  = 2'(w);
        cp.mask  = 4'(m);
        cp.wb    = (st == 0);
        cp.data  = (st == 0) ? 16'(r) : 16'h0;
        req_q.push_back(rq);
        comp_q.push_back(cp);
    endtask

    // Monitor: request fields checked against the queue head every cycle they
    // are valid (so a stall must keep them stable); head popped on handshake.
    // Every done pulse pops and checks one expected completion.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL req_unexpected: got addr %0h, expected no request", mem_req_addr);
                end else begin
                    check("req_we", 32'(mem_req_we), 32'(req_q[0].we));
                    check("req_addr", 32'(mem_req_addr), 32'(req_q[0].addr));
                    check("req_wdata", 32'(mem_req_wdata), 32'(req_q[0].wdata));
                    if (mem_req_ready) begin
                        $display("req  we=%0b addr=%h wdata=%h", mem_req_we, mem_req_addr, mem_req_wdata);
                        void'(req_q.pop_front());
                    end
                end
            end
            if (done_bit) begin
                $display("done warp=%0d mask=%h wb=%0b data=%h", warp_num_clear, threads_mask_clear, wb_valid, wb_data);
                if (comp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL done_unexpected: got done warp %0d, expected no completion", warp_num_clear);
                end else begin
                    check("done_warp", 32'(warp_num_clear), 32'(comp_q[0].warp));
                    check("done_mask", 32'(threads_mask_clear), 32'(comp_q[0].mask));
                    check("wb_valid", 32'(wb_valid), 32'(comp_q[0].wb));
                    if (comp_q[0].wb) begin
                        check("wb_data", 32'(wb_data), 32'(comp_q[0].data));
                        check("wb_warp", 32'(wb_warp_num), 32'(comp_q[0].warp));
                        check("wb_mask", 32'(wb_threads_mask), 32'(comp_q[0].mask));
                    end
                    void'(comp_q.pop_front());
                end
            end else begin
                check("wb_without_done", 32'(wb_valid), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    int s4_warp [3] = '{0, 1, 3};
    int s4_mask [3] = '{1, 2, 8};
    int s4_rdy  [7] = '{1, 0, 1, 0, 1, 1, 1};
    int s3_warp [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset          = 1'b1;
        issue_valid    = 1'b0;
        drive_issue(0, 0, 0, 0, 0);
        issue_valid    = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 16'h0;

        // Reset state
        tick();
        tick();
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_req_valid", 32'(mem_req_valid), 0);
        check("rst_done", 32'(done_bit), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        reset = 1'b0;

        // Single load
        drive_issue(2, 'h3, 0, 'h0040, 0);
        mem_req_ready = 1'b1;
        check("s1_ready", 32'(issue_ready), 1);
        push_exp(2, 'h3, 0, 'h0040, 0, 'hBEEF);
        tick();
        issue_valid = 1'b0;
        check("s1_req_valid", 32'(mem_req_valid), 1);
        tick();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 16'hBEEF;
        check("s1_done_early", 32'(done_bit), 0);
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 16'h0;
        check("s1_done", 32'(done_bit), 1);
        check("s1_warp", 32'(warp_num_clear), 2);
        check("s1_mask", 32'(threads_mask_clear), 3);
        check("s1_wb_valid", 32'(wb_valid), 1);
        check("s1_wb_data", 32'(wb_data), 'hBEEF);
        tick();
        check("s1_done_pulse", 32'(done_bit), 0);

        // Store
        drive_issue(1, 'h5, 1, 'h0080, 'h1234);
        push_exp(1, 'h5, 1, 'h0080, 'h1234, 0);
        tick();
        issue_valid = 1'b0;
        check("s2_req_we", 32'(mem_req_we), 1);
        check("s2_req_wdata", 32'(mem_req_wdata), 'h1234);
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("s2_done", 32'(done_bit), 1);
        check("s2_warp", 32'(warp_num_clear), 1);
        check("s2_mask", 32'(threads_mask_clear), 5);
        check("s2_wb_valid", 32'(wb_valid), 0);
        tick();

        // Full: fresh reset so the perf counters cover this scenario only
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(s3_warp[i], i + 1, 0, 'h0100 + i, 0);
            check("s3_ready_fill", 32'(issue_ready), 1);
            push_exp(s3_warp[i], i + 1, 0, 'h0100 + i, 0, 'hD000 + i);
            tick();
        end
        drive_issue(s3_warp[4], 'hF, 0, 'h0104, 0);
        for (int k = 0; k < 3; k++) begin
            check("s3_full", 32'(issue_ready), 0);
            tick();
        end
        mem_req_ready = 1'b1;
        check("s3_full_send", 32'(issue_ready), 0);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 16'hD000;
        check("s3_full_retire", 32'(issue_ready), 0);
        tick();
        mem_resp_valid = 1'b0;
        check("s3_ready_after_retire", 32'(issue_ready), 1);
        push_exp(s3_warp[4], 'hF, 0, 'h0104, 0, 'hD004);
        tick();
        issue_valid = 1'b0;
        check("s3_fifth_accepted", 32'(mem_req_valid), 1);
        mem_req_ready = 1'b1;
        repeat (5) tick();
        mem_req_ready = 1'b0;
        check("s3_all_sent", 32'(mem_req_valid), 0);
        for (int j = 1; j < 5; j++) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 16'(32'hD000 + 32'(j));
            tick();
            check("s3_drain_done", 32'(done_bit), 1);
            check("s3_drain_warp", 32'(warp_num_clear), 32'(s3_warp[j]));
        end
        mem_resp_valid = 1'b0;
        tick();
        check("s3_drain_idle", 32'(done_bit), 0);
`ifdef LSU_TRACKER_PERF_EN
        check("perf_full_stalls", perf_full_stalls, 5);
        check("perf_completions", perf_completions, 5);
`endif

        // Ordering with request backpressure
        for (int c = 0; c < 7; c++) begin
            mem_req_ready = 1'(s4_rdy[c]);
            if (c < 3) begin
                drive_issue(s4_warp[c], s4_mask[c], 0, 'h0200 + c, 0);
                push_exp(s4_warp[c], s4_mask[c], 0, 'h0200 + c, 0, 'hE000 + c);
            end else begin
                issue_valid = 1'b0;
            end
            tick();
        end
        issue_valid   = 1'b0;
        mem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 16'(32'hE000 + 32'(j));
            tick();
            check("s4_done", 32'(done_bit), 1);
            check("s4_order_warp", 32'(warp_num_clear), 32'(s4_warp[j]));
        end
        mem_resp_valid = 1'b0;
        tick();
        check("s4_idle", 32'(done_bit), 0);

        // Spurious response, then reset with two entries outstanding
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 16'hDEAD;
        tick();
        mem_resp_valid = 1'b0;
        check("s5_spurious_done", 32'(done_bit), 0);
        check("s5_spurious_ready", 32'(issue_ready), 1);
        check("s5_spurious_req", 32'(mem_req_valid), 0);
        mem_req_ready = 1'b1;
        drive_issue(2, 'h6, 0, 'h0300, 0);
        push_exp(2, 'h6, 0, 'h0300, 0, 0);
        tick();
        drive_issue(3, 'h9, 1, 'h0304, 'h5A5A);
        push_exp(3, 'h9, 1, 'h0304, 'h5A5A, 0);
        tick();
        issue_valid   = 1'b0;
        mem_req_ready = 1'b0;
        tick();
        check("s5_pending_req", 32'(mem_req_valid), 1);
        reset = 1'b1;
        req_q.delete();
        comp_q.delete();
        tick();
        check("s5_rst_ready", 32'(issue_ready), 1);
        check("s5_rst_req_valid", 32'(mem_req_valid), 0);
        check("s5_rst_req_addr", 32'(mem_req_addr), 0);
        check("s5_rst_done", 32'(done_bit), 0);
        check("s5_rst_wb_valid", 32'(wb_valid), 0);
        check("s5_rst_warp_clear", 32'(warp_num_clear), 0);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        check("s5_post_rst_done", 32'(done_bit), 0);

        check("req_queue_drained", 32'(req_q.size()), 0);
        check("comp_queue_drained", 32'(comp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
